// File: rtl/modinv_helper_pkg.sv
// Shared constants for the modular-inverse helpers: word width, clog2 and
// the per-pass cycle window boundaries expressed relative to the operand word count n.
package modinv_helper_pkg;

    localparam int WORD_W = 32;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    localparam int RD_FIRST  = 1;
    localparam int DAT_FIRST = 2;
    localparam int WR_FIRST  = 3;

    function automatic int proc_num_cycles(input int n);
        return n + 3;
    endfunction

    function automatic int rd_last(input int n);
        return n;
    endfunction

    function automatic int dat_last(input int n);
        return n + 1;
    endfunction

    function automatic int wr_last(input int n);
        return n + 2;
    endfunction

endpackage

// File: rtl/modinv_helper_reduce_precalc_if.sv
// Control handshake plus S/Q read and U/V write buffer ports of the reduce precalc helper.
// slave = the helper itself, master = controller and buffer side.
interface modinv_helper_reduce_precalc_if #(
    parameter int BUFFER_ADDR_BITS = 4
);
    import modinv_helper_pkg::*;

    logic                        ena;
    logic                        rdy;
    logic                        k_is_nul;
    logic                        s_is_odd;
    logic [BUFFER_ADDR_BITS-1:0] s_addr;
    logic [BUFFER_ADDR_BITS-1:0] q_addr;
    logic [WORD_W-1:0]           s_din;
    logic [WORD_W-1:0]           q_din;
    logic [BUFFER_ADDR_BITS-1:0] u_addr;
    logic                        u_wren;
    logic [WORD_W-1:0]           u_dout;
    logic [BUFFER_ADDR_BITS-1:0] v_addr;
    logic                        v_wren;
    logic [WORD_W-1:0]           v_dout;

    modport slave (
        input  ena, k_is_nul, s_din, q_din,
        output rdy, s_is_odd, s_addr, q_addr,
               u_addr, u_wren, u_dout, v_addr, v_wren, v_dout
    );

    modport master (
        output ena, k_is_nul, s_din, q_din,
        input  rdy, s_is_odd, s_addr, q_addr,
               u_addr, u_wren, u_dout, v_addr, v_wren, v_dout
    );

endinterface

// File: rtl/modinv_helper_addsub32_carry.sv
// 32-bit adder with carry-in/carry-out for word-serial multi-word arithmetic.
// Latency: combinational, no backpressure.
module modinv_helper_addsub32_carry
    import modinv_helper_pkg::*;
(
    input  logic [WORD_W-1:0] a_dat,
    input  logic [WORD_W-1:0] b_dat,
    input  logic              ci,
    output logic [WORD_W-1:0] sum_dat,
    output logic              co
);

    assign {co, sum_dat} = {1'b0, a_dat} + {1'b0, b_dat} + {{WORD_W{1'b0}}, ci};

endmodule

// File: rtl/modinv_helper_reduce_precalc.sv
// Word-serial producer of U = S>>1 and V = (S+Q)>>1 (full width incl. top carry); latency N+3 clocks
// ena->rdy, no backpressure (ena ignored while busy). Option: MODINV_HELPER_PRECALC_V_GATE_EN gates V writes by S parity.
module modinv_helper_reduce_precalc
    import modinv_helper_pkg::*;
#(
    parameter int BUFFER_NUM_WORDS = 9,
    parameter int BUFFER_ADDR_BITS = 4
) (
    input logic                          clk,
    input logic                          rst_n,
    modinv_helper_reduce_precalc_if.slave bus
);

    localparam int N        = BUFFER_NUM_WORDS;
    localparam int CNT_BITS = clog2(proc_num_cycles(N));

    typedef logic [CNT_BITS-1:0]         cnt_t;
    typedef logic [BUFFER_ADDR_BITS-1:0] addr_t;

    localparam cnt_t C_RD_FIRST  = cnt_t'(RD_FIRST);
    localparam cnt_t C_RD_LAST   = cnt_t'(rd_last(N));
    localparam cnt_t C_DAT_FIRST = cnt_t'(DAT_FIRST);
    localparam cnt_t C_DAT_LAST  = cnt_t'(dat_last(N));
    localparam cnt_t C_WR_FIRST  = cnt_t'(WR_FIRST);
    localparam cnt_t C_WR_LAST   = cnt_t'(wr_last(N));

    cnt_t              cnt_q, cnt_d;
    addr_t             rd_addr_q, rd_addr_d;
    logic              carry_q, carry_d;
    logic [WORD_W-1:0] s_prev_q, s_prev_d;
    logic [WORD_W-1:0] sum_prev_q, sum_prev_d;
    logic              s_is_odd_q, s_is_odd_d;

    logic [WORD_W-1:0] sum_lo;
    logic              sum_co;
    logic              rd_win, dat_win, wr_win, wr_top;
    logic              wr_en;
    cnt_t              wr_idx;

    modinv_helper_addsub32_carry u_add (
        .a_dat   (bus.s_din),
        .b_dat   (bus.q_din),
        .ci      (carry_q),
        .sum_dat (sum_lo),
        .co      (sum_co)
    );

    assign rd_win  = (cnt_q >= C_RD_FIRST)  && (cnt_q <= C_RD_LAST);
    assign dat_win = (cnt_q >= C_DAT_FIRST) && (cnt_q <= C_DAT_LAST);
    assign wr_win  = (cnt_q >= C_WR_FIRST)  && (cnt_q <= C_WR_LAST);
    assign wr_top  = (cnt_q == C_WR_LAST);
    assign wr_idx  = cnt_q - C_WR_FIRST;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            rd_addr_q  <= '0;
            carry_q    <= 1'b0;
            s_prev_q   <= '0;
            sum_prev_q <= '0;
            s_is_odd_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rd_addr_q  <= rd_addr_d;
            carry_q    <= carry_d;
            s_prev_q   <= s_prev_d;
            sum_prev_q <= sum_prev_d;
            s_is_odd_q <= s_is_odd_d;
        end
    end

    always_comb begin
        cnt_d      = cnt_q;
        rd_addr_d  = '0;
        carry_d    = carry_q;
        s_prev_d   = s_prev_q;
        sum_prev_d = sum_prev_q;
        s_is_odd_d = s_is_odd_q;

        if (cnt_q == '0) begin
            cnt_d = bus.ena ? cnt_t'(1) : '0;
        end else if (cnt_q == C_WR_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + cnt_t'(1);
        end

        if (rd_win) begin
            rd_addr_d = rd_addr_q + addr_t'(1);
        end

        // Carry chain starts fresh each pass; it is held after the last word for the top-word shift-in.
        if (cnt_q <= C_RD_FIRST) begin
            carry_d = 1'b0;
        end else if (dat_win) begin
            s_prev_d   = bus.s_din;
            sum_prev_d = sum_lo;
            carry_d    = sum_co;
        end

        if (cnt_q == C_DAT_FIRST) begin
            s_is_odd_d = bus.s_din[0];
        end
    end

    always_comb begin
        bus.rdy      = (cnt_q == '0);
        bus.s_is_odd = s_is_odd_q;
        bus.s_addr   = rd_addr_q;
        bus.q_addr   = rd_addr_q;

        wr_en      = wr_win && !bus.k_is_nul;
        bus.u_wren = wr_en;
`ifdef MODINV_HELPER_PRECALC_V_GATE_EN
        bus.v_wren = wr_en && s_is_odd_q;
`else
        bus.v_wren = wr_en;
`endif

        bus.u_addr = '0;
        bus.v_addr = '0;
        bus.u_dout = '0;
        bus.v_dout = '0;
        if (wr_win) begin
            bus.u_addr = BUFFER_ADDR_BITS'(wr_idx);
            bus.v_addr = BUFFER_ADDR_BITS'(wr_idx);
            // Each output word takes its MSB from the next-higher input word; the top word takes 0 / the final carry.
            if (wr_top) begin
                bus.u_dout = {1'b0,    s_prev_q[WORD_W-1:1]};
                bus.v_dout = {carry_q, sum_prev_q[WORD_W-1:1]};
            end else begin
                bus.u_dout = {bus.s_din[0], s_prev_q[WORD_W-1:1]};
                bus.v_dout = {sum_lo[0],    sum_prev_q[WORD_W-1:1]};
            end
        end
    end

endmodule
